// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N-channel round-robin / forced-select stream multiplexer with 1-entry output buffer
module rr_stream_mux #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel,
    output logic [DATA_W-1:0]      out_data,
    output logic [SEL_W-1:0]       out_ch,
    output logic                   out_valid,
    input  logic                   out_ready
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } buf_state_t;

    buf_state_t          r_state;
    buf_state_t          w_state_nxt;
    logic [DATA_W-1:0]   r_out_data;
    logic [SEL_W-1:0]    r_out_ch;
    logic [SEL_W-1:0]    r_last_grant;

    logic                w_load_en;
    logic                w_rr_vld;
    logic [SEL_W-1:0]    w_rr_idx;
    logic                w_fs_vld;
    logic [SEL_W-1:0]    w_fs_idx;
    logic                w_grant_vld;
    logic [SEL_W-1:0]    w_grant_idx;
    logic [DATA_W-1:0]   w_grant_data;
    logic [N_CH-1:0]     w_ready;

    // The buffer can take a new word when it is empty or is being drained this cycle
    assign w_load_en = (r_state == ST_EMPTY) || out_ready;

    // Round-robin search: first valid channel after the last one served, wrapping to 0
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_idx = '0;
        for (int k = 1; k <= N_CH; k++) begin
            for (int i = 0; i < N_CH; i++) begin
                if (!w_rr_vld && in_valid[i] &&
                    (((int'(r_last_grant) + k) % N_CH) == i)) begin
                    w_rr_vld = 1'b1;
                    w_rr_idx = SEL_W'(i);
                end
            end
        end
    end

    // Forced select: an out-of-range sel matches no channel and therefore grants nothing
    always_comb begin
        w_fs_vld = 1'b0;
        w_fs_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                w_fs_vld = 1'b1;
                w_fs_idx = SEL_W'(i);
            end
        end
    end

    // Final grant, gated by buffer availability
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        if (w_load_en) begin
            w_grant_vld = mode ? w_fs_vld : w_rr_vld;
            w_grant_idx = mode ? w_fs_idx : w_rr_idx;
        end
    end

    // One-hot ready for the granted channel; held low while in reset
    always_comb begin
        w_ready      = '0;
        w_grant_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_grant_vld && w_grant_idx == SEL_W'(i)) begin
                w_ready[i]   = 1'b1;
                w_grant_data = in_data[i*DATA_W +: DATA_W];
            end
        end
        if (!rst_n) begin
            w_ready = '0;
        end
    end

    // Buffer state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Buffer next state: reload on grant whenever loading is allowed, otherwise hold
    always_comb begin
        w_state_nxt = r_state;
        if (w_load_en) begin
            w_state_nxt = w_grant_vld ? ST_FULL : ST_EMPTY;
        end
    end

    // Capture granted word and remember who was served so round-robin resumes after it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_data   <= '0;
            r_out_ch     <= '0;
            r_last_grant <= SEL_W'(N_CH - 1);
        end else if (w_grant_vld) begin
            r_out_data   <= w_grant_data;
            r_out_ch     <= w_grant_idx;
            r_last_grant <= w_grant_idx;
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_valid = (r_state == ST_FULL);

endmodule
